// File: rtl/ps2_key_rx_if.sv
// Keyboard event bundle produced by ps2_key_rx: the key event word plus the raw byte
// stream and its framing-error strobe.
interface ps2_key_rx_if;
  logic [10:0] ps2_key;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  modport master (output ps2_key, output byte_valid, output byte_data, output frame_err);
  modport slave  (input  ps2_key, input  byte_valid, input  byte_data, input  frame_err);
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: conditions the raw clock/data pair, frames 11-bit words and
// decodes prefix bytes (E0/F0/E1) into the toggle/pressed/extended/scancode event word.
module ps2_key_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 49152
) (
  input  logic          clk_49m,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_key_rx_if.master  key_if
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data line.
  logic [1:0]    raw_s1, raw_s2, filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_f_d;
  logic          fall;
  logic          sample;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_err;

  logic [10:0]   ps2_key;
  logic          ext, rel;
  logic [2:0]    skip;

  // Synchronizer stage: idle-high lines reset high so no phantom edge follows reset.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      raw_s1 <= 2'b11;
      raw_s2 <= 2'b11;
    end else begin
      raw_s1 <= {ps2_data, ps2_clk};
      raw_s2 <= raw_s1;
    end
  end

  // Counter filter stage: a level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      filt    <= 2'b11;
      clk_f_d <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      clk_f_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (raw_s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          fcnt[i] <= '0;
          filt[i] <= raw_s2[i];
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall   = clk_f_d & ~filt[0];
  assign sample = filt[1];

  // Frame stage: one state step per filtered clock falling edge, watchdog otherwise.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!sample) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {sample, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= sample;
            state   <= STOP;
          end
          STOP: begin
            // Odd parity over data plus parity bit, and a high stop bit.
            if (sample && ^{shreg, par_bit}) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err  <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Decode stage: prefix flags survive framing errors; E1 swallows the rest of the pause sequence.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      ps2_key <= '0;
      ext     <= 1'b0;
      rel     <= 1'b0;
      skip    <= '0;
    end else if (byte_valid) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else if (byte_data == 8'hE1) begin
        skip <= 3'd7;
      end else if (byte_data == 8'hE0) begin
        ext <= 1'b1;
      end else if (byte_data == 8'hF0) begin
        rel <= 1'b1;
      end else begin
        ps2_key <= {~ps2_key[10], ~rel, ext, byte_data};
        ext     <= 1'b0;
        rel     <= 1'b0;
      end
    end
  end

  assign key_if.ps2_key    = ps2_key;
  assign key_if.byte_valid = byte_valid;
  assign key_if.byte_data  = byte_data;
  assign key_if.frame_err  = frame_err;

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- Deserializes a raw PS/2 keyboard clock/data pair into the 11-bit ps2_key event word consumed by the core's keyboard-to-button mapper.
- Word format: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- Handles prefix bytes (E0 extended, F0 release, E1 pause sequence), parity/framing checks and mid-frame timeout.
- Sits in the 49 MHz system domain in place of the HPS-supplied key word for builds driving a physical keyboard.

Parameters:
- FILTER_LEN, 8, consecutive equal synchronized samples required before a filtered ps2_clk/ps2_data level changes.
- TIMEOUT, 49152, system clocks without a filtered ps2_clk falling edge before a partial frame is discarded (~1 ms at 49.152 MHz).

Ports:
- clk_49m  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- ps2_key  out  11  event word; [10] toggles once per completed key event.
- byte_valid  out  1  one-cycle strobe: good frame received.
- byte_data  out  8  last good byte; valid when byte_valid is high, held otherwise.
- frame_err  out  1  one-cycle strobe: parity error, bad start/stop, or timeout.

Behaviour:
- Reset: asynchronous, active-low. While reset=0: ps2_key=0, byte_data=0, byte_valid=0, frame_err=0. Also cleared: filters (held high), frame FSM=IDLE, prefix flags, skip counter.
- Input conditioning:
  - Each line passes a 2-FF synchronizer, then a counter filter.
  - The filtered level changes only after FILTER_LEN identical consecutive synchronized samples.
  - A falling edge is detected when filtered clk goes 1->0; data is sampled on that cycle.
- Frame FSM (states IDLE, DATA, PARITY, STOP), one transition per clk falling edge:
  - IDLE: sample 0 -> DATA, bit count 0. Sample 1 -> stay IDLE, no error.
  - DATA: shift LSB first; after the 8th bit -> PARITY.
  - PARITY: latch bit -> STOP.
  - STOP: frame is good if stop bit=1 and data+parity has odd weight. Then, in the cycle after the stop-bit edge: byte_valid=1, byte_data updated. Otherwise frame_err=1, no byte. Either way -> IDLE.
  - Timeout counter: resets on every falling edge; counts only outside IDLE. On reaching TIMEOUT, raise frame_err for one cycle, go to IDLE, discard partial bits. Prefix flags are kept.
- Decoder, acting on each byte_valid:
  - Skip counter nonzero: decrement, no event.
  - E1: set skip=7, no event.
  - E0: set ext=1.
  - F0: set rel=1.
  - Any other byte B: in the same cycle, ps2_key <= {~ps2_key[10], ~rel, ext, B}; then clear ext and rel.
  - Event latency: ps2_key updates 1 cycle after byte_valid.
- Boundaries:
  - Bytes arriving with flags already set simply re-set them (E0 E0 is the same as E0).
  - frame_err does not clear ext/rel.
  - AA (BAT) and FA/FE responses are ordinary codes and produce events.
  - A reset in mid-frame takes effect immediately; the next frame must begin with a fresh start bit.
  - No host-to-device transmission; lines are input-only.

Test Plan:
- Send a valid frame for 0x1C (parity 0, stop 1), bit period 80 µs -> byte_valid pulse with byte_data=0x1C; ps2_key goes from 0x000 to 0x61C (toggle=1, pressed=1, ext=0).
- Send F0 then 1C -> exactly one event; ps2_key=0x01C (toggle back to 0, pressed=0); no event emitted on F0.
- Send E0 75 then E0 F0 75 -> events 0x775 then 0x175; ext clears after each event.
- Send 0x29 with parity bit inverted -> frame_err 1-cycle pulse, no byte_valid, ps2_key unchanged; a following good 0x29 frame produces event 0x629 (or toggled equivalent).
- Send a start bit plus 4 data bits, then idle 1.2 ms -> frame_err once at TIMEOUT cycles after the last edge, FSM back in IDLE; the next full frame decodes correctly. Repeat with 1 ns glitches on ps2_clk shorter than FILTER_LEN cycles -> no extra bits captured.
- Send the pause sequence E1 14 77 E1 F0 14 F0 77, then 16 -> no events during the sequence, single event 0x616 (or toggled) afterwards. Assert reset=0 mid-byte -> all outputs 0 immediately.
